// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one up-counting timer among NREQ requesters.
// Optional macro TIMER_ARBITER_PAUSE_EN adds a pause input that freezes the count.
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_value,
`ifdef TIMER_ARBITER_PAUSE_EN
  input  logic              pause,
`endif
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   own_q, own_d;
  logic [W-1:0]    val_q, val_d;
  logic [W-1:0]    count_q, count_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   own_nxt;
  logic            hold;

`ifdef TIMER_ARBITER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // The owner after the current one gets top priority next time.
  assign own_nxt = (own_q == PW'(NREQ - 1)) ? '0 : own_q + PW'(1);

  // First pending requester scanning from the round-robin pointer.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    val_d   = val_q;
    count_d = count_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        if (found) begin
          state_d = RUN;
          own_d   = pick;
          val_d   = req_value[int'(pick)*W +: W];
          grant_d = NREQ'(1) << pick;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Abort wins over a terminal-count match in the same cycle.
        if (!req[own_q]) begin
          state_d = IDLE;
          ptr_d   = own_nxt;
          count_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (count_q == val_q) begin
          state_d = DONE;
          done_d  = grant_q;
        end else if (!hold) begin
          count_d = count_q + W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = own_nxt;
        count_d = '0;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      val_q   <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      val_q   <= val_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule
